// File: rtl/tlc_pkg.sv
// Shared definitions for the traffic-light controller: detector state encoding,
// default timing parameters and a small saturating-increment helper.
`timescale 1ns/1ps
package tlc_pkg;

  localparam int DEF_DEBOUNCE    = 4;
  localparam int DEF_HOLD        = 8;
  localparam int DEF_STUCK_LIMIT = 200;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_ARMING    = 3'd1,
    ST_PRESENT   = 3'd2,
    ST_RELEASING = 3'd3,
    ST_HOLD      = 3'd4,
    ST_FAULT     = 3'd5
  } det_state_t;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer bringing an asynchronous level into the i_clk domain.
`timescale 1ns/1ps
module sync_2ff (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_q
);

  logic meta_reg;
  logic sync_reg;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      meta_reg <= 1'b0;
      sync_reg <= 1'b0;
    end else begin
      meta_reg <= i_d;
      sync_reg <= meta_reg;
    end
  end

  assign o_q = sync_reg;

endmodule

// File: rtl/ew_vehicle_detect.sv
// East-west inductive-loop vehicle detector: debounces the loop, holds demand
// after departure, counts arrivals and declares a fail-safe fault on a stuck loop.
`timescale 1ns/1ps
module ew_vehicle_detect
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE    = DEF_DEBOUNCE,
  parameter int HOLD        = DEF_HOLD,
  parameter int STUCK_LIMIT = DEF_STUCK_LIMIT
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_loop_raw,
  input  logic       i_clr_count,
  output logic       o_EW_vd,
  output logic       o_presence,
  output logic       o_fault,
  output logic [7:0] o_veh_count
);

  localparam logic [7:0] DB_LAST    = 8'(DEBOUNCE - 1);
  localparam logic [7:0] HOLD_LAST  = 8'(HOLD - 1);
  localparam logic [7:0] STUCK_LAST = 8'(STUCK_LIMIT - 1);

  det_state_t state_reg, state_next;
  logic [7:0] cnt_reg, cnt_next;
  logic [7:0] stuck_reg, stuck_next;
  logic [7:0] count_reg, count_next;
  logic       vd_reg, vd_next;
  logic       arrive;
  logic       loop_s;

  sync_2ff u_sync (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_d     (i_loop_raw),
    .o_q     (loop_s)
  );

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_reg <= ST_IDLE;
      cnt_reg   <= 8'd0;
      stuck_reg <= 8'd0;
      count_reg <= 8'd0;
      vd_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      stuck_reg <= stuck_next;
      count_reg <= count_next;
      vd_reg    <= vd_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    stuck_next = stuck_reg;
    vd_next    = vd_reg;
    arrive     = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        vd_next = 1'b0;
        if (loop_s) begin
          state_next = ST_ARMING;
          cnt_next   = 8'd0;
        end
      end
      ST_ARMING: begin
        if (loop_s) begin
          if (cnt_reg == DB_LAST) begin
            state_next = ST_PRESENT;
            vd_next    = 1'b1;
            stuck_next = 8'd0;
            arrive     = 1'b1;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end else begin
          // A re-arrival that fails debounce returns to HOLD if demand is still up
          state_next = vd_reg ? ST_HOLD : ST_IDLE;
          cnt_next   = 8'd0;
        end
      end
      ST_PRESENT, ST_RELEASING: begin
        if (stuck_reg == STUCK_LAST) begin
          state_next = ST_FAULT;
          cnt_next   = 8'd0;
          vd_next    = 1'b1;
        end else begin
          stuck_next = stuck_reg + 8'd1;
          if (state_reg == ST_PRESENT) begin
            if (!loop_s) begin
              state_next = ST_RELEASING;
              cnt_next   = 8'd0;
            end
          end else if (loop_s) begin
            state_next = ST_PRESENT;
          end else if (cnt_reg == DB_LAST) begin
            state_next = ST_HOLD;
            cnt_next   = 8'd0;
          end else begin
            cnt_next = cnt_reg + 8'd1;
          end
        end
      end
      ST_HOLD: begin
        if (loop_s) begin
          state_next = ST_ARMING;
          cnt_next   = 8'd0;
        end else if (cnt_reg == HOLD_LAST) begin
          state_next = ST_IDLE;
          cnt_next   = 8'd0;
          vd_next    = 1'b0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      ST_FAULT: begin
        vd_next = 1'b1;
        if (loop_s) begin
          cnt_next = 8'd0;
        end else if (cnt_reg == DB_LAST) begin
          state_next = ST_HOLD;
          cnt_next   = 8'd0;
        end else begin
          cnt_next = cnt_reg + 8'd1;
        end
      end
      default: begin
        state_next = ST_IDLE;
        cnt_next   = 8'd0;
        vd_next    = 1'b0;
      end
    endcase
  end

  // A clear coinciding with an arrival keeps that arrival
  always_comb begin
    count_next = count_reg;
    if (arrive) begin
      count_next = i_clr_count ? 8'd1 : sat_inc8(count_reg);
    end else if (i_clr_count) begin
      count_next = 8'd0;
    end
  end

  assign o_EW_vd     = vd_reg;
  assign o_presence  = (state_reg == ST_PRESENT) || (state_reg == ST_RELEASING);
  assign o_fault     = (state_reg == ST_FAULT);
  assign o_veh_count = count_reg;

endmodule

// File: tb/tb_ew_vehicle_detect.sv
// Directed bench for ew_vehicle_detect: latency, glitch rejection, hold re-arrival,
// count clear/saturation, stuck-loop fault and reset mid-presence.
`timescale 1ns/1ps
module tb_ew_vehicle_detect;

  logic       clk;
  logic       rst_n;
  logic       raw;
  logic       clr;
  logic       ew_vd;
  logic       presence;
  logic       fault;
  logic [7:0] veh_count;

  int n_checks = 0;
  int n_errors = 0;

  ew_vehicle_detect dut (
    .i_clk       (clk),
    .i_rst_n     (rst_n),
    .i_loop_raw  (raw),
    .i_clr_count (clr),
    .o_EW_vd     (ew_vd),
    .o_presence  (presence),
    .o_fault     (fault),
    .o_veh_count (veh_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end else begin
      $display("ok   %s value=%0d", tag, got);
    end
  endtask

  // Advance n rising edges; inputs change and outputs are sampled 1ns after each edge
  task automatic ticks(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got=0 exp=1");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0;
    raw   = 1'b0;
    clr   = 1'b0;
    ticks(2);
    chk("rst_vd", 32'(ew_vd), 0);
    chk("rst_presence", 32'(presence), 0);
    chk("rst_fault", 32'(fault), 0);
    chk("rst_count", 32'(veh_count), 0);
    rst_n = 1'b1;
    ticks(2);

    // Three-cycle glitch from IDLE is rejected
    raw = 1'b1;
    ticks(3);
    raw = 1'b0;
    ticks(4);
    chk("glitch_vd_e6", 32'(ew_vd), 0);
    ticks(6);
    chk("glitch_vd_end", 32'(ew_vd), 0);
    chk("glitch_count", 32'(veh_count), 0);

    // Arrival held 20 cycles: rise at edge 6, fall at r+14
    raw = 1'b1;
    ticks(6);
    chk("arr_vd_e5", 32'(ew_vd), 0);
    chk("arr_pres_e5", 32'(presence), 0);
    ticks(1);
    chk("arr_vd_e6", 32'(ew_vd), 1);
    chk("arr_pres_e6", 32'(presence), 1);
    chk("arr_count", 32'(veh_count), 1);
    ticks(13);
    raw = 1'b0;
    ticks(6);
    chk("dep_pres_r5", 32'(presence), 1);
    ticks(1);
    chk("dep_pres_r6", 32'(presence), 0);
    chk("dep_vd_r6", 32'(ew_vd), 1);
    ticks(7);
    chk("dep_vd_r13", 32'(ew_vd), 1);
    ticks(1);
    chk("dep_vd_r14", 32'(ew_vd), 0);
    chk("dep_pres_idle", 32'(presence), 0);
    chk("dep_fault_idle", 32'(fault), 0);

    // Clear alone
    clr = 1'b1;
    ticks(1);
    clr = 1'b0;
    chk("clr_alone", 32'(veh_count), 0);

    // Second arrival during HOLD: demand never drops, count reaches 2
    raw = 1'b1;
    ticks(7);
    chk("hold1_vd", 32'(ew_vd), 1);
    chk("hold1_count", 32'(veh_count), 1);
    ticks(3);
    raw = 1'b0;
    for (int i = 0; i < 8; i++) begin
      ticks(1);
      chk("hold_gap_vd", 32'(ew_vd), 1);
    end
    raw = 1'b1;
    for (int i = 0; i < 7; i++) begin
      ticks(1);
      chk("hold_rearm_vd", 32'(ew_vd), 1);
    end
    chk("hold2_count", 32'(veh_count), 2);
    raw = 1'b0;
    ticks(20);
    chk("hold2_idle_vd", 32'(ew_vd), 0);

    // Clear coincident with an arrival
    raw = 1'b1;
    ticks(6);
    clr = 1'b1;
    ticks(1);
    clr = 1'b0;
    chk("clr_arrive_count", 32'(veh_count), 1);
    raw = 1'b0;
    ticks(20);

    // Stuck loop: fault at edge 206, cleared after 4 cycles of s=0
    raw = 1'b1;
    ticks(206);
    chk("stuck_fault_e205", 32'(fault), 0);
    ticks(1);
    chk("stuck_fault_e206", 32'(fault), 1);
    chk("stuck_vd_e206", 32'(ew_vd), 1);
    chk("stuck_pres_e206", 32'(presence), 0);
    ticks(93);
    raw = 1'b0;
    ticks(5);
    chk("stuck_fault_r4", 32'(fault), 1);
    ticks(1);
    chk("stuck_fault_r5", 32'(fault), 0);
    chk("stuck_vd_r5", 32'(ew_vd), 1);
    ticks(7);
    chk("stuck_vd_r12", 32'(ew_vd), 1);
    ticks(1);
    chk("stuck_vd_r13", 32'(ew_vd), 0);
    chk("stuck_count", 32'(veh_count), 2);

    // Saturation at 255 over 260 arrivals
    clr = 1'b1;
    ticks(1);
    clr = 1'b0;
    for (int i = 0; i < 260; i++) begin
      raw = 1'b1;
      ticks(8);
      if (i == 0)   chk("sat_first", 32'(veh_count), 1);
      if (i == 253) chk("sat_254", 32'(veh_count), 254);
      if (i == 259) chk("sat_cap", 32'(veh_count), 255);
      raw = 1'b0;
      ticks(8);
    end
    ticks(20);
    chk("sat_final", 32'(veh_count), 255);

    // Reset mid-PRESENT, then full latency again
    raw = 1'b1;
    ticks(10);
    chk("pre_rst_pres", 32'(presence), 1);
    rst_n = 1'b0;
    ticks(1);
    chk("midrst_vd", 32'(ew_vd), 0);
    chk("midrst_pres", 32'(presence), 0);
    chk("midrst_fault", 32'(fault), 0);
    chk("midrst_count", 32'(veh_count), 0);
    rst_n = 1'b1;
    ticks(6);
    chk("rearr_vd_e5", 32'(ew_vd), 0);
    ticks(1);
    chk("rearr_vd_e6", 32'(ew_vd), 1);
    chk("rearr_count", 32'(veh_count), 1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
